mem_serial_interface: RTL and testbench
=======================================

Name: mem_serial_interface

Overview:
- Serial link engine between the instruction decoder and an external memory device, over narrow full-duplex pin buses.
- TX side: serialises decoder commands (header symbol, then address/data payload symbols) onto tx_pins, pulling symbols from the decoder one per cycle.
- RX side: detects response start symbols on rx_pins and frames the following read-data payload for the decoder, which samples rx_pins directly.
- TX and RX run independently.

Parameters:
- IO_BITS, 2, pin bus width in bits, for both TX and RX.
- PAYLOAD_CYCLES, 8, cycles per 16-bit payload. Must equal 16/IO_BITS and be even.
- CW (local), $clog2(PAYLOAD_CYCLES)+1, counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_command_valid  in  1  decoder requests a transaction.
- tx_command  in  2  header: READ_16=1, WRITE_8=2, WRITE_16=3. Value 0 is illegal and is ignored.
- tx_command_started  out  1  command accepted this cycle.
- tx_active  out  1  transaction in payload phase.
- tx_data  in  IO_BITS  current payload symbol from decoder.
- tx_data_next  out  1  tx_data consumed this cycle.
- tx_done  out  1  last payload symbol this cycle.
- tx_counter  out  CW  payload symbol index.
- tx_pins  out  IO_BITS  serial output; 0 when idle.
- rx_pins  in  IO_BITS  serial input; 0 when idle.
- rx_started  out  1  response start detected.
- rx_sbs  out  IO_BITS  start-bit symbol, equal to rx_pins.
- rx_sbs_valid  out  1  rx_sbs meaningful this cycle.
- rx_active  out  1  receiving payload.
- rx_data_valid  out  1  rx_pins carries a data symbol this cycle.
- rx_done  out  1  response complete this cycle.
- rx_counter  out  CW  payload symbol index.

Behaviour:
- Reset (async, rst_n=0): TX and RX go to IDLE; tx_counter=rx_counter=0. All outputs read 0 when idle, with tx_pins=0 and no pulses. Reset mid-transaction aborts it immediately; no done pulse is issued.
- TX states: IDLE, PAYLOAD.
- TX IDLE:
  - tx_command_started = tx_command_valid && tx_command!=0, combinational.
  - When started, tx_pins=tx_command in that same cycle (the header symbol), and the next state is PAYLOAD with tx_counter=0.
  - Otherwise tx_pins=0.
  - tx_command_valid is ignored while not IDLE.
- TX PAYLOAD:
  - tx_active=1; tx_pins=tx_data combinationally; tx_data_next=1 every cycle.
  - tx_counter increments each cycle.
  - Length N per header: READ_16 = PAYLOAD_CYCLES (address only); WRITE_16 = 2*PAYLOAD_CYCLES (address then data); WRITE_8 = PAYLOAD_CYCLES + PAYLOAD_CYCLES/2.
  - tx_done=1 when tx_counter==N-1; the next state is IDLE.
  - A new command can start the cycle after tx_done, so back-to-back commands are separated by 0 idle cycles.
  - Payload symbols are sent LSB symbol first; ordering is the decoder's responsibility.
- RX states: IDLE, DATA.
- RX IDLE:
  - rx_sbs=rx_pins.
  - rx_sbs_valid = rx_started = (rx_pins!=0).
  - If rx_pins==RX_SB_READ_16 (1), the next state is DATA with rx_counter=0.
  - Any other nonzero value is a one-symbol acknowledgment: rx_done=1 in the same cycle and RX stays IDLE.
- RX DATA:
  - rx_active=1 and rx_data_valid=1 each cycle; rx_counter increments.
  - rx_done=1 at rx_counter==PAYLOAD_CYCLES-1; the next state is IDLE.
  - rx_pins is not interpreted as start bits while in DATA.
  - rx_sbs_valid=0 in DATA.
- TX and RX may be active simultaneously with no interaction.
- The RX side has no timeout. A symbol following rx_done is treated as a new start symbol.

Test Plan:
- Reset then idle: rst_n low 2 cycles, no stimulus -> tx_pins=0, all pulses 0, counters 0.
- READ_16 command (tx_data cycling 0..3):
  - cycle 0: tx_command_started=1, tx_pins=1.
  - next 8 cycles: tx_active=1, tx_data_next=1, tx_pins=tx_data, tx_counter 0..7.
  - tx_done at count 7; tx_pins=0 afterwards.
- WRITE_8 and WRITE_16: payload lengths 12 and 16 cycles respectively, tx_done on the final symbol.
- Back-to-back: tx_command_valid held high across two WRITE_16 commands -> second header appears the cycle after the first tx_done.
- RX read response: rx_pins=1, then 8 data symbols -> rx_started/rx_sbs_valid pulse with rx_sbs=1; rx_data_valid high 8 cycles with rx_counter 0..7; rx_done on the 8th.
- RX ack plus abort:
  - rx_pins=2 for one cycle -> rx_sbs_valid=1 and rx_done=1 in the same cycle, rx_active stays 0.
  - Asserting rst_n=0 mid-payload -> returns to idle, tx_pins=0.

Source files
------------

// File: rtl/mem_serial_interface.sv
// -----------------------------------------------------------------------------
// mem_serial_interface
//
// Serial link engine between the instruction decoder and an external memory
// device. The TX side sends a header symbol followed by a payload pulled from
// the decoder one symbol per cycle. The RX side recognises response start
// symbols and frames the read-data payload that follows. TX and RX are fully
// independent.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   tx_command_valid        decoder requests a transaction
//   tx_command [1:0]        header: 1=READ_16, 2=WRITE_8, 3=WRITE_16 (0 ignored)
//   tx_command_started      command accepted this cycle (header on tx_pins)
//   tx_active               TX in payload phase
//   tx_data [IO_BITS-1:0]   current payload symbol from decoder
//   tx_data_next            tx_data consumed this cycle
//   tx_done                 last payload symbol this cycle
//   tx_counter [CW-1:0]     payload symbol index
//   tx_pins [IO_BITS-1:0]   serial output, 0 when idle
//   rx_pins [IO_BITS-1:0]   serial input, 0 when idle
//   rx_started              response start symbol seen
//   rx_sbs [IO_BITS-1:0]    start symbol (rx_pins while idle)
//   rx_sbs_valid            rx_sbs meaningful this cycle
//   rx_active               receiving payload
//   rx_data_valid           rx_pins carries a data symbol this cycle
//   rx_done                 response complete this cycle
//   rx_counter [CW-1:0]     payload symbol index
// -----------------------------------------------------------------------------
module mem_serial_interface #(
   parameter int IO_BITS        = 2,
   parameter int PAYLOAD_CYCLES = 8,
   localparam int CW            = $clog2(PAYLOAD_CYCLES) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tx_command_valid,
   input  logic [1:0]         tx_command,
   output logic               tx_command_started,
   output logic               tx_active,
   input  logic [IO_BITS-1:0] tx_data,
   output logic               tx_data_next,
   output logic               tx_done,
   output logic [CW-1:0]      tx_counter,
   output logic [IO_BITS-1:0] tx_pins,
   input  logic [IO_BITS-1:0] rx_pins,
   output logic               rx_started,
   output logic [IO_BITS-1:0] rx_sbs,
   output logic               rx_sbs_valid,
   output logic               rx_active,
   output logic               rx_data_valid,
   output logic               rx_done,
   output logic [CW-1:0]      rx_counter
);

   // Index of the final payload symbol for each header. The counter is one bit
   // wider than PAYLOAD_CYCLES needs so a two-payload WRITE_16 still fits.
   localparam logic [CW-1:0] LAST_R16 = CW'(PAYLOAD_CYCLES - 1);
   localparam logic [CW-1:0] LAST_W8  = CW'(PAYLOAD_CYCLES + PAYLOAD_CYCLES / 2 - 1);
   localparam logic [CW-1:0] LAST_W16 = CW'(2 * PAYLOAD_CYCLES - 1);
   localparam logic [IO_BITS-1:0] RX_SB_READ_16 = IO_BITS'(1);

   typedef enum logic {TX_IDLE, TX_PAYLOAD} tx_state_t;
   typedef enum logic {RX_IDLE, RX_DATA}    rx_state_t;

   tx_state_t         tx_state_reg;
   logic [CW-1:0]     tx_counter_reg;
   logic [CW-1:0]     tx_last_reg;
   logic [CW-1:0]     tx_last_next;
   logic              tx_start;

   rx_state_t         rx_state_reg;
   logic [CW-1:0]     rx_counter_reg;
   logic              rx_idle;
   logic              rx_symbol;

   // ---------------------------------------------------------------- TX side
   assign tx_start = (tx_state_reg == TX_IDLE) && tx_command_valid && (tx_command != 2'd0);

   always_comb begin
      tx_last_next = LAST_R16;
      case (tx_command)
         2'd2:    tx_last_next = LAST_W8;
         2'd3:    tx_last_next = LAST_W16;
         default: tx_last_next = LAST_R16;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_reg   <= TX_IDLE;
         tx_counter_reg <= '0;
         tx_last_reg    <= '0;
      end else begin
         case (tx_state_reg)
            TX_IDLE: begin
               if (tx_start) begin
                  tx_state_reg   <= TX_PAYLOAD;
                  tx_counter_reg <= '0;
                  tx_last_reg    <= tx_last_next;
               end
            end
            TX_PAYLOAD: begin
               // Counter returns to 0 on the last symbol so it reads 0 when idle.
               if (tx_counter_reg == tx_last_reg) begin
                  tx_state_reg   <= TX_IDLE;
                  tx_counter_reg <= '0;
               end else begin
                  tx_counter_reg <= tx_counter_reg + 1'b1;
               end
            end
            default: tx_state_reg <= TX_IDLE;
         endcase
      end
   end

   assign tx_command_started = tx_start;
   assign tx_active          = (tx_state_reg == TX_PAYLOAD);
   assign tx_data_next       = tx_active;
   assign tx_done            = tx_active && (tx_counter_reg == tx_last_reg);
   assign tx_counter         = tx_counter_reg;
   // Header goes out in the acceptance cycle, payload passes straight through.
   assign tx_pins            = tx_active ? tx_data :
                               (tx_start ? IO_BITS'(tx_command) : '0);

   // ---------------------------------------------------------------- RX side
   assign rx_idle   = (rx_state_reg == RX_IDLE);
   assign rx_symbol = rx_idle && (rx_pins != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_reg   <= RX_IDLE;
         rx_counter_reg <= '0;
      end else begin
         case (rx_state_reg)
            RX_IDLE: begin
               if (rx_pins == RX_SB_READ_16) begin
                  rx_state_reg   <= RX_DATA;
                  rx_counter_reg <= '0;
               end
            end
            RX_DATA: begin
               if (rx_counter_reg == CW'(PAYLOAD_CYCLES - 1)) begin
                  rx_state_reg   <= RX_IDLE;
                  rx_counter_reg <= '0;
               end else begin
                  rx_counter_reg <= rx_counter_reg + 1'b1;
               end
            end
            default: rx_state_reg <= RX_IDLE;
         endcase
      end
   end

   assign rx_started    = rx_symbol;
   assign rx_sbs_valid  = rx_symbol;
   assign rx_sbs        = rx_idle ? rx_pins : '0;
   assign rx_active     = (rx_state_reg == RX_DATA);
   assign rx_data_valid = rx_active;
   assign rx_counter    = rx_counter_reg;
   // Any non-read start symbol is a single-symbol acknowledgment.
   assign rx_done       = (rx_symbol && (rx_pins != RX_SB_READ_16)) ||
                          (rx_active && (rx_counter_reg == CW'(PAYLOAD_CYCLES - 1)));

endmodule

// File: tb/tb_mem_serial_interface.sv
module tb_mem_serial_interface;

   localparam int IO_BITS = 2;
   localparam int PC      = 8;
   localparam int CW      = $clog2(PC) + 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               tx_command_valid;
   logic [1:0]         tx_command;
   logic               tx_command_started;
   logic               tx_active;
   logic [IO_BITS-1:0] tx_data;
   logic               tx_data_next;
   logic               tx_done;
   logic [CW-1:0]      tx_counter;
   logic [IO_BITS-1:0] tx_pins;
   logic [IO_BITS-1:0] rx_pins;
   logic               rx_started;
   logic [IO_BITS-1:0] rx_sbs;
   logic               rx_sbs_valid;
   logic               rx_active;
   logic               rx_data_valid;
   logic               rx_done;
   logic [CW-1:0]      rx_counter;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   mem_serial_interface #(.IO_BITS(IO_BITS), .PAYLOAD_CYCLES(PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .tx_command_valid(tx_command_valid), .tx_command(tx_command),
      .tx_command_started(tx_command_started), .tx_active(tx_active),
      .tx_data(tx_data), .tx_data_next(tx_data_next), .tx_done(tx_done),
      .tx_counter(tx_counter), .tx_pins(tx_pins),
      .rx_pins(rx_pins), .rx_started(rx_started), .rx_sbs(rx_sbs),
      .rx_sbs_valid(rx_sbs_valid), .rx_active(rx_active),
      .rx_data_valid(rx_data_valid), .rx_done(rx_done), .rx_counter(rx_counter)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------ model
   // Transaction-level view: how many payload symbols remain and which one is next.
   function automatic int tx_len(input logic [1:0] c);
      case (c)
         2'd1:    return PC;
         2'd2:    return PC + PC / 2;
         2'd3:    return 2 * PC;
         default: return 0;
      endcase
   endfunction

   int m_tx_left, m_tx_idx, m_rx_left, m_rx_idx;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tx_left <= 0; m_tx_idx <= 0; m_rx_left <= 0; m_rx_idx <= 0;
      end else begin
         if (m_tx_left > 0) begin
            m_tx_left <= m_tx_left - 1;
            m_tx_idx  <= m_tx_idx + 1;
         end else if (tx_command_valid && tx_command != 0) begin
            m_tx_left <= tx_len(tx_command);
            m_tx_idx  <= 0;
         end
         if (m_rx_left > 0) begin
            m_rx_left <= m_rx_left - 1;
            m_rx_idx  <= m_rx_idx + 1;
         end else if (rx_pins == 1) begin
            m_rx_left <= PC;
            m_rx_idx  <= 0;
         end
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         if (m_tx_left > 0) begin
            check("m_tx_started", int'(tx_command_started), 0);
            check("m_tx_active",  int'(tx_active), 1);
            check("m_tx_next",    int'(tx_data_next), 1);
            check("m_tx_pins",    int'(tx_pins), int'(tx_data));
            check("m_tx_counter", int'(tx_counter), m_tx_idx);
            check("m_tx_done",    int'(tx_done), int'(m_tx_left == 1));
         end else begin
            check("m_tx_started", int'(tx_command_started), int'(tx_command_valid && tx_command != 0));
            check("m_tx_active",  int'(tx_active), 0);
            check("m_tx_next",    int'(tx_data_next), 0);
            check("m_tx_pins",    int'(tx_pins),
                  (tx_command_valid && tx_command != 0) ? int'(tx_command) : 0);
            check("m_tx_counter", int'(tx_counter), 0);
            check("m_tx_done",    int'(tx_done), 0);
         end
         if (m_rx_left > 0) begin
            check("m_rx_started", int'(rx_started), 0);
            check("m_rx_sbs_v",   int'(rx_sbs_valid), 0);
            check("m_rx_active",  int'(rx_active), 1);
            check("m_rx_dv",      int'(rx_data_valid), 1);
            check("m_rx_counter", int'(rx_counter), m_rx_idx);
            check("m_rx_done",    int'(rx_done), int'(m_rx_left == 1));
         end else begin
            check("m_rx_started", int'(rx_started), int'(rx_pins != 0));
            check("m_rx_sbs_v",   int'(rx_sbs_valid), int'(rx_pins != 0));
            check("m_rx_sbs",     int'(rx_sbs), int'(rx_pins));
            check("m_rx_active",  int'(rx_active), 0);
            check("m_rx_dv",      int'(rx_data_valid), 0);
            check("m_rx_counter", int'(rx_counter), 0);
            check("m_rx_done",    int'(rx_done), int'(rx_pins > 1));
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   // Advance one cycle; tx_data cycles 0..3 on every cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      tx_data = tx_data + 1'b1;
   endtask

   // Count payload cycles until tx_done (bounded).
   task automatic wait_tx_done(output int n);
      bit seen = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx_active) n++;
         if (tx_done) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      if (!seen) check("tx_done_timeout", 0, 1);
   endtask

   int n;
   logic [IO_BITS-1:0] rx_vec [PC] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd1, 2'd0, 2'd3};

   initial begin
      rst_n = 1'b0; tx_command_valid = 1'b0; tx_command = 2'd0;
      tx_data = '0; rx_pins = '0;

      // Reset then idle
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_tx_pins", int'(tx_pins), 0);
      check("rst_tx_counter", int'(tx_counter), 0);
      check("rst_rx_counter", int'(rx_counter), 0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      $display("txn reset/idle done");

      // Illegal header 0 is ignored
      tx_command_valid = 1'b1; tx_command = 2'd0;
      @(negedge clk);
      check("illegal_started", int'(tx_command_started), 0);
      tick();
      tx_command_valid = 1'b0;
      $display("txn illegal header 0");

      // READ_16
      tx_command_valid = 1'b1; tx_command = 2'd1;
      @(negedge clk);
      check("r16_started", int'(tx_command_started), 1);
      check("r16_header", int'(tx_pins), 1);
      tick();
      tx_command_valid = 1'b0;
      for (int k = 0; k < PC; k++) begin
         @(negedge clk);
         check("r16_counter", int'(tx_counter), k);
         check("r16_pins", int'(tx_pins), int'(tx_data));
         check("r16_done", int'(tx_done), int'(k == PC - 1));
         tick();
      end
      @(negedge clk);
      check("r16_after_pins", int'(tx_pins), 0);
      check("r16_after_active", int'(tx_active), 0);
      $display("txn READ_16 payload=8");

      // WRITE_8
      tick();
      tx_command_valid = 1'b1; tx_command = 2'd2;
      @(negedge clk);
      tick();
      tx_command_valid = 1'b0;
      wait_tx_done(n);
      check("w8_len", n, 12);
      $display("txn WRITE_8 payload=%0d", n);

      // WRITE_16
      tick();
      tx_command_valid = 1'b1; tx_command = 2'd3;
      @(negedge clk);
      tick();
      tx_command_valid = 1'b0;
      wait_tx_done(n);
      check("w16_len", n, 16);
      $display("txn WRITE_16 payload=%0d", n);

      // Back-to-back WRITE_16 with valid held high
      tick();
      tx_command_valid = 1'b1; tx_command = 2'd3;
      wait_tx_done(n);
      check("b2b_len1", n, 16);
      tick();
      @(negedge clk);
      check("b2b_started", int'(tx_command_started), 1);
      check("b2b_header", int'(tx_pins), 3);
      tick();
      tx_command_valid = 1'b0;
      wait_tx_done(n);
      check("b2b_len2", n, 16);
      tick();
      $display("txn back-to-back WRITE_16 x2");

      // RX read response
      rx_pins = 2'd1;
      @(negedge clk);
      check("rx_started", int'(rx_started), 1);
      check("rx_sbs_valid", int'(rx_sbs_valid), 1);
      check("rx_sbs", int'(rx_sbs), 1);
      for (int k = 0; k < PC; k++) begin
         tick();
         rx_pins = rx_vec[k];
         @(negedge clk);
         check("rx_dv", int'(rx_data_valid), 1);
         check("rx_counter", int'(rx_counter), k);
         check("rx_done", int'(rx_done), int'(k == PC - 1));
      end
      tick();
      rx_pins = 2'd0;
      @(negedge clk);
      check("rx_after_active", int'(rx_active), 0);
      $display("txn RX read response 8 symbols");

      // RX ack
      tick();
      rx_pins = 2'd2;
      @(negedge clk);
      check("ack_sbs_valid", int'(rx_sbs_valid), 1);
      check("ack_done", int'(rx_done), 1);
      check("ack_active", int'(rx_active), 0);
      tick();
      rx_pins = 2'd3;
      tick();
      rx_pins = 2'd0;
      $display("txn RX ack symbols 2,3");

      // TX and RX overlapping, then reset mid-payload
      tick();
      tx_command_valid = 1'b1; tx_command = 2'd3;
      rx_pins = 2'd1;
      tick();
      tx_command_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rx_pins = rx_vec[k];
         tick();
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_tx_pins", int'(tx_pins), 0);
      check("abort_tx_active", int'(tx_active), 0);
      check("abort_tx_done", int'(tx_done), 0);
      check("abort_rx_active", int'(rx_active), 0);
      tick();
      rx_pins = 2'd0;
      rst_n = 1'b1;
      tick(); tick();
      @(negedge clk);
      check("post_abort_pins", int'(tx_pins), 0);
      $display("txn overlap + reset abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
